// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : hazard_scoreboard
// Brief    : Pipeline stall/flush/forward control with mul/div scoreboard
//            (built only when HAZARD_MD_EN is defined) and syscall drain FSM.
// Revision : 1.0
// ============================================================================
module hazard_scoreboard #(
  parameter int REG_W  = 5,
  parameter int MD_LAT = 4,
  parameter int CNT_W  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sig_branch_d,
  input  logic             sig_jal_d,
  input  logic             sig_syscall_d,
  input  logic             sig_md_d,
  input  logic             sig_reg_write_d,
  input  logic [REG_W-1:0] rs_d,
  input  logic [REG_W-1:0] rt_d,
  input  logic [REG_W-1:0] write_reg_d,
  input  logic [REG_W-1:0] rs_e,
  input  logic [REG_W-1:0] rt_e,
  input  logic [REG_W-1:0] write_reg_e,
  input  logic [REG_W-1:0] write_reg_m,
  input  logic [REG_W-1:0] write_reg_w,
  input  logic             sig_reg_write_e,
  input  logic             sig_reg_write_m,
  input  logic             sig_reg_write_w,
  input  logic             sig_mem_to_reg_e,
  input  logic             sig_mem_to_reg_m,
  input  logic             md_start_e,
  input  logic [REG_W-1:0] md_dest_e,
  output logic             stall_f,
  output logic             stall_d,
  output logic             flush_e,
  output logic             forward_a_d,
  output logic             forward_b_d,
  output logic [1:0]       forward_a_e,
  output logic [1:0]       forward_b_e,
  output logic             md_busy,
  output logic             md_wb_valid,
  output logic [REG_W-1:0] md_wb_reg
);

  localparam logic [1:0] c_ST_IDLE  = 2'd0;
  localparam logic [1:0] c_ST_DRAIN = 2'd1;
  localparam logic [1:0] c_ST_GO    = 2'd2;

  logic       w_load_use, w_branch_stall, w_jal_stall, w_md_stall, w_sys_stall;
  logic       w_stall_other, w_pipe_busy, w_md_drain;
  logic       r_jal_seen;
  logic [1:0] r_state, w_state_nxt;

  always_comb begin
    forward_a_e = 2'b00;
    forward_b_e = 2'b00;
    if (rs_e != '0 && sig_reg_write_m && rs_e == write_reg_m)      forward_a_e = 2'b10;
    else if (rs_e != '0 && sig_reg_write_w && rs_e == write_reg_w) forward_a_e = 2'b01;
    if (rt_e != '0 && sig_reg_write_m && rt_e == write_reg_m)      forward_b_e = 2'b10;
    else if (rt_e != '0 && sig_reg_write_w && rt_e == write_reg_w) forward_b_e = 2'b01;
  end

  assign forward_a_d = (rs_d != '0) && (rs_d == write_reg_m) && sig_reg_write_m;
  assign forward_b_d = (rt_d != '0) && (rt_d == write_reg_m) && sig_reg_write_m;

  assign w_load_use = sig_mem_to_reg_e && (write_reg_e != '0) &&
                      ((write_reg_e == rs_d) || (write_reg_e == rt_d));

  assign w_branch_stall = sig_branch_d && (
      (sig_reg_write_e && (write_reg_e != '0) &&
       ((write_reg_e == rs_d) || (write_reg_e == rt_d))) ||
      (sig_mem_to_reg_m && (write_reg_m != '0) &&
       ((write_reg_m == rs_d) || (write_reg_m == rt_d))));

`ifdef HAZARD_MD_EN
  logic [2**REG_W-1:0] r_pend, w_pend_nxt;
  logic [CNT_W-1:0]    r_cnt;
  logic [REG_W-1:0]    r_md_dest;
  logic                w_md_load, w_md_done;

  // A start while a mul/div is already in flight is ignored entirely.
  assign w_md_load = md_start_e && (r_cnt == '0);
  assign w_md_done = (r_cnt == CNT_W'(1));

  always_comb begin
    w_pend_nxt = r_pend;
    if (w_md_done) w_pend_nxt[r_md_dest] = 1'b0;
    if (w_md_load && md_dest_e != '0) w_pend_nxt[md_dest_e] = 1'b1;
    w_pend_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend    <= '0;
      r_cnt     <= '0;
      r_md_dest <= '0;
    end else begin
      r_pend <= w_pend_nxt;
      if (w_md_load) begin
        r_cnt     <= CNT_W'(MD_LAT);
        r_md_dest <= md_dest_e;
      end else if (r_cnt != '0) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end
    end
  end

  assign md_busy     = (r_cnt != '0);
  assign md_wb_valid = w_md_done;
  assign md_wb_reg   = w_md_done ? r_md_dest : '0;
  assign w_md_drain  = md_busy;

  assign w_md_stall = r_pend[rs_d] || r_pend[rt_d] ||
                      (r_pend[write_reg_d] && sig_reg_write_d) ||
                      (w_md_load && (md_dest_e != '0) &&
                       ((md_dest_e == rs_d) || (md_dest_e == rt_d) ||
                        (md_dest_e == write_reg_d))) ||
                      (sig_md_d && md_busy && !md_wb_valid);
`else
  logic w_unused_md;
  assign w_unused_md = ^{md_start_e, md_dest_e, sig_md_d, sig_reg_write_d, write_reg_d};
  assign md_busy     = 1'b0;
  assign md_wb_valid = 1'b0;
  assign md_wb_reg   = '0;
  assign w_md_drain  = 1'b0;
  assign w_md_stall  = 1'b0;
`endif

  assign w_pipe_busy = sig_reg_write_e || sig_reg_write_m || sig_reg_write_w || w_md_drain;

  // DRAIN stalls unconditionally, so entering it costs at least one cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_sys_stall = 1'b0;
    case (r_state)
      c_ST_IDLE: begin
        if (sig_syscall_d && w_pipe_busy) begin
          w_sys_stall = 1'b1;
          w_state_nxt = c_ST_DRAIN;
        end
      end
      c_ST_DRAIN: begin
        w_sys_stall = 1'b1;
        if (!w_pipe_busy) w_state_nxt = c_ST_GO;
      end
      c_ST_GO:  w_state_nxt = c_ST_IDLE;
      default:  w_state_nxt = c_ST_IDLE;
    endcase
  end

  assign w_stall_other = w_load_use || w_branch_stall || w_md_stall || w_sys_stall;
  assign w_jal_stall   = sig_jal_d && !r_jal_seen;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= c_ST_IDLE;
      r_jal_seen <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_jal_seen <= sig_jal_d && !w_stall_other;
    end
  end

  assign stall_f = rst_n && (w_stall_other || w_jal_stall);
  assign stall_d = stall_f;
  assign flush_e = stall_f;

endmodule
`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_scoreboard
// Brief    : Directed self-checking bench for hazard_scoreboard.
// Revision : 1.0
// ============================================================================
module tb_hazard_scoreboard;

`ifdef HAZARD_MD_EN
  localparam bit c_MD = 1'b1;
`else
  localparam bit c_MD = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sig_branch_d, sig_jal_d, sig_syscall_d, sig_md_d, sig_reg_write_d;
  logic [4:0] rs_d, rt_d, write_reg_d, rs_e, rt_e;
  logic [4:0] write_reg_e, write_reg_m, write_reg_w, md_dest_e;
  logic       sig_reg_write_e, sig_reg_write_m, sig_reg_write_w;
  logic       sig_mem_to_reg_e, sig_mem_to_reg_m, md_start_e;
  logic       stall_f, stall_d, flush_e, forward_a_d, forward_b_d;
  logic [1:0] forward_a_e, forward_b_e;
  logic       md_busy, md_wb_valid;
  logic [4:0] md_wb_reg;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hazard_scoreboard #(.REG_W(5), .MD_LAT(4), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .sig_branch_d(sig_branch_d), .sig_jal_d(sig_jal_d), .sig_syscall_d(sig_syscall_d),
    .sig_md_d(sig_md_d), .sig_reg_write_d(sig_reg_write_d),
    .rs_d(rs_d), .rt_d(rt_d), .write_reg_d(write_reg_d), .rs_e(rs_e), .rt_e(rt_e),
    .write_reg_e(write_reg_e), .write_reg_m(write_reg_m), .write_reg_w(write_reg_w),
    .sig_reg_write_e(sig_reg_write_e), .sig_reg_write_m(sig_reg_write_m),
    .sig_reg_write_w(sig_reg_write_w), .sig_mem_to_reg_e(sig_mem_to_reg_e),
    .sig_mem_to_reg_m(sig_mem_to_reg_m), .md_start_e(md_start_e), .md_dest_e(md_dest_e),
    .stall_f(stall_f), .stall_d(stall_d), .flush_e(flush_e),
    .forward_a_d(forward_a_d), .forward_b_d(forward_b_d),
    .forward_a_e(forward_a_e), .forward_b_e(forward_b_e),
    .md_busy(md_busy), .md_wb_valid(md_wb_valid), .md_wb_reg(md_wb_reg)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // All three stall outputs are one function; compare them together.
  task automatic check_stall(input string tag, input logic exp);
    check(tag, {5'd0, stall_f, stall_d, flush_e}, {5'd0, exp, exp, exp});
  endtask

  task automatic clear_inputs();
    sig_branch_d = 0; sig_jal_d = 0; sig_syscall_d = 0; sig_md_d = 0; sig_reg_write_d = 0;
    rs_d = 0; rt_d = 0; write_reg_d = 0; rs_e = 0; rt_e = 0;
    write_reg_e = 0; write_reg_m = 0; write_reg_w = 0; md_dest_e = 0;
    sig_reg_write_e = 0; sig_reg_write_m = 0; sig_reg_write_w = 0;
    sig_mem_to_reg_e = 0; sig_mem_to_reg_m = 0; md_start_e = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    clear_inputs();
    rst_n = 1'b0;
    // A load-use pattern during reset must not raise the stalls.
    sig_mem_to_reg_e = 1; write_reg_e = 5'd8; rt_d = 5'd8;
    #2;
    check_stall("reset_stall", 1'b0);
    check("reset_busy", {7'd0, md_busy}, 8'd0);
    check("reset_wb", {2'd0, md_wb_valid, md_wb_reg}, 8'd0);
    tick(); tick();
    clear_inputs();
    rst_n = 1'b1;
    tick();

    // Forwarding
    rs_e = 5; write_reg_m = 5; write_reg_w = 5; sig_reg_write_m = 1; sig_reg_write_w = 1;
    #1 check("fwd_a_e_m", {6'd0, forward_a_e}, 8'd2);
    sig_reg_write_m = 0;
    #1 check("fwd_a_e_w", {6'd0, forward_a_e}, 8'd1);
    sig_reg_write_m = 1; rs_e = 0;
    #1 check("fwd_a_e_r0", {6'd0, forward_a_e}, 8'd0);
    rs_d = 5; rt_d = 6;
    #1 check("fwd_d", {6'd0, forward_a_d, forward_b_d}, 8'd2);
    sig_reg_write_m = 0; rt_e = 5;
    #1 check("fwd_b_e_w", {6'd0, forward_b_e}, 8'd1);
    clear_inputs();
    tick();

    // Load-use, then load in M forwards
    sig_mem_to_reg_e = 1; write_reg_e = 8; rt_d = 8;
    #1 check_stall("load_use", 1'b1);
    tick();
    clear_inputs();
    sig_mem_to_reg_m = 1; write_reg_m = 8; sig_reg_write_m = 1; rt_e = 8;
    #1 check("load_fwd_b_e", {6'd0, forward_b_e}, 8'd2);
    check_stall("load_use_done", 1'b0);
    clear_inputs();
    tick();

    // Branch
    sig_branch_d = 1; rs_d = 3; sig_reg_write_e = 1; write_reg_e = 3;
    #1 check_stall("branch_e", 1'b1);
    rs_d = 0; write_reg_e = 0;
    #1 check_stall("branch_r0", 1'b0);
    sig_reg_write_e = 0; sig_mem_to_reg_m = 1; write_reg_m = 4; rt_d = 4;
    #1 check_stall("branch_m_load", 1'b1);
    clear_inputs();
    tick();

    // JAL: one bubble
    sig_jal_d = 1;
    #1 check_stall("jal_c1", 1'b1);
    tick();
    check_stall("jal_c2", 1'b0);
    clear_inputs();
    tick();

    // Syscall drain
    sig_syscall_d = 1; sig_reg_write_m = 1;
    #1 check_stall("sys_idle_trig", 1'b1);
    tick();
    check_stall("sys_drain_busy", 1'b1);
    sig_reg_write_m = 0;
    #1 check_stall("sys_drain_clear", 1'b1);
    tick();
    check_stall("sys_go", 1'b0);
    tick();
    check_stall("sys_idle_empty", 1'b0);
    clear_inputs();
    tick();

    // Mul/div, MD_LAT=4, issue at t
    md_start_e = 1; md_dest_e = 9; rs_d = 9;
    #1 check_stall("md_t", c_MD);
    check("md_t_busy", {7'd0, md_busy}, 8'd0);
    tick();
    md_start_e = 0; md_dest_e = 0;
    for (int k = 1; k <= 3; k++) begin
      check_stall("md_mid_stall", c_MD);
      check("md_mid_flags", {6'd0, md_busy, md_wb_valid}, {6'd0, c_MD, 1'b0});
      tick();
    end
    check_stall("md_t4_stall", c_MD);
    check("md_t4_wb", {1'b0, md_busy, md_wb_valid, md_wb_reg},
          c_MD ? {1'b0, 1'b1, 1'b1, 5'd9} : 8'd0);
    tick();
    check_stall("md_t5_release", 1'b0);
    check("md_t5_flags", {6'd0, md_busy, md_wb_valid}, 8'd0);
    clear_inputs();
    tick();

    // Reset during a mul/div discards it
    md_start_e = 1; md_dest_e = 9;
    tick();
    md_start_e = 0; md_dest_e = 0;
    tick();
    rst_n = 1'b0;
    #1 check("rst_mid_busy", {7'd0, md_busy}, 8'd0);
    tick();
    rst_n = 1'b1;
    rs_d = 9;
    for (int k = 0; k < 6; k++) begin
      #1 check("rst_after_flags", {5'd0, md_busy, md_wb_valid, stall_f}, 8'd0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised, clocked successor to the pipeline hazard unit: generates stall, flush and forwarding controls for the five-stage pipeline. It adds a per-register scoreboard and latency counter for a multi-cycle mul/div unit, a drain state machine for syscalls, and a single-bubble JAL stall. It sits beside the decode/execute registers and drives the fetch/decode enables, the execute flush and the operand bypass muxes.

## Interface
- REG_W, 5: register index width; the scoreboard holds 2**REG_W bits.
- MD_LAT, 4: mul/div latency in cycles, legal range 1..15.
- CNT_W, 4: width of the mul/div down-counter; must satisfy 2**CNT_W > MD_LAT.

- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- sig_branch_d, sig_jal_d, sig_syscall_d, sig_md_d  in  1 each  decode-stage op class.
- sig_reg_write_d  in  1  decode instruction writes a GPR.
- rs_d, rt_d, write_reg_d  in  REG_W each  decode source and destination registers.
- rs_e, rt_e  in  REG_W each  execute-stage sources.
- write_reg_e, write_reg_m, write_reg_w  in  REG_W each  destinations in E, M and W.
- sig_reg_write_e, sig_reg_write_m, sig_reg_write_w  in  1 each  register-write valid per stage.
- sig_mem_to_reg_e, sig_mem_to_reg_m  in  1 each  instruction is a load.
- md_start_e  in  1  mul/div issues from E this cycle.
- md_dest_e  in  REG_W  mul/div destination register.
- stall_f, stall_d, flush_e  out  1 each  hold the PC, hold IF/ID, bubble ID/EX.
- forward_a_d, forward_b_d  out  1 each  decode bypass from M.
- forward_a_e, forward_b_e  out  2 each  execute bypass: 10 selects M, 01 selects W, 00 selects the register file.
- md_busy  out  1  a mul/div is in flight.
- md_wb_valid  out  1  one-cycle mul/div writeback strobe.
- md_wb_reg  out  REG_W  writeback destination.

## Operation
- **Forwarding (combinational).**
  - forward_*_e selects M over W; a source of register 0 never forwards.
  - forward_*_d = source ≠ 0, source == write_reg_m, and sig_reg_write_m.
- **Load-use stall.** sig_mem_to_reg_e, write_reg_e ≠ 0, and write_reg_e equals rs_d or rt_d.
- **Branch stall.** sig_branch_d together with either:
  - sig_reg_write_e and write_reg_e equals rs_d or rt_d; or
  - sig_mem_to_reg_m and write_reg_m equals rs_d or rt_d.
  - Register 0 never matches.
- **JAL.** Flop jal_seen is set on any cycle with sig_jal_d and stall_d=0 from all other causes, and cleared otherwise. The JAL stall is sig_jal_d && !jal_seen, giving exactly one bubble per JAL.
- **Scoreboard** (pend[2**REG_W-1:0]).
  - md_start_e sets pend[md_dest_e] and loads the counter with MD_LAT.
  - The counter decrements each cycle while non-zero.
  - On the cycle the counter equals 1: md_wb_valid=1, md_wb_reg=dest, and pend[dest] clears at the following edge.
  - A set and a clear on the same edge for the same register: set wins.
  - md_busy = (counter ≠ 0).
- **Mul/div stall.** Asserted when any of these holds:
  - pend[rs_d] or pend[rt_d] is set;
  - pend[write_reg_d] is set and sig_reg_write_d (WAW);
  - md_start_e and md_dest_e matches rs_d, rt_d or write_reg_d;
  - sig_md_d and md_busy, except on the md_wb_valid cycle.
  - Register 0 is never pending.
- **Syscall FSM.**
  - IDLE → DRAIN when sig_syscall_d and any of sig_reg_write_e/m/w or md_busy is set.
  - DRAIN holds the stall until all of those are clear, then → GO.
  - GO asserts no syscall stall and → IDLE unconditionally.
  - A syscall with the pipeline already empty passes in IDLE with no stall.
- **Stall combination.** stall_f = stall_d = flush_e = OR of the load-use, branch, JAL, mul/div and syscall (IDLE-trigger or DRAIN) stalls.

## Timing
- **Reset** (asynchronous, takes effect immediately):
  - pend=0, counter=0, jal_seen=0, FSM=IDLE.
  - md_busy=0, md_wb_valid=0, md_wb_reg=0.
  - stall_f, stall_d and flush_e are forced to 0 while rst_n=0.
  - A reset during a mul/div discards it; no md_wb_valid is issued.
- **Mul/div issued at cycle t:**
  - md_busy is high during t+1 .. t+MD_LAT.
  - md_wb_valid is high in cycle t+MD_LAT.
  - Dependent decode is stalled in t .. t+MD_LAT and released in t+MD_LAT+1.
  - A back-to-back mul/div in D issues from E at t+MD_LAT+1.
- **Other stalls.** All other stall terms are combinational with zero latency. The syscall stall adds at least one cycle when the FSM enters DRAIN.
- **Ignored input.** md_start_e while md_busy is a protocol violation (decode prevents it); the block ignores it.

## Configuration
- **HAZARD_MD_EN defined:** scoreboard, counter and mul/div stall are present as specified above.
- **HAZARD_MD_EN undefined:**
  - The scoreboard and counter are not built.
  - md_start_e, md_dest_e and sig_md_d are ignored.
  - md_busy, md_wb_valid and md_wb_reg are tied to 0.
  - The mul/div stall term is 0, and the syscall drain ignores md_busy.

## Test plan
- **Forwarding:** rs_e=5, write_reg_m=5, write_reg_w=5, both write enables set → forward_a_e=10. Repeat with rs_e=0 → 00.
- **Load-use:** sig_mem_to_reg_e=1, write_reg_e=8, rt_d=8 → stall_f=stall_d=flush_e=1 for one cycle. Next cycle (load in M), forward_b_e=10.
- **JAL:** sig_jal_d held 2 cycles with no other hazard → stall high in cycle 1 only.
- **Mul/div (MD_LAT=4):** md_start_e at t with md_dest_e=9, then rs_d=9 in D → stall in t..t+4, md_wb_valid=1 and md_wb_reg=9 at t+4, stall low at t+5.
- **Syscall:** sig_syscall_d with sig_reg_write_m=1 → FSM goes to DRAIN and stalls. After the E/M/W write enables are all 0 → GO with stall low, then IDLE.
- **Reset mid-operation:** rst_n low at t+2 of a mul/div → md_busy=0, pend clear, and no md_wb_valid after release.
